cache_ctrl: RTL

//  Responder side of the processor memory-request interface used by the fetch and memory stages.

---
 rtl/mem_sys_pkg.sv | 28 ++
 rtl/cache_ctrl_if.sv | 35 +++
 rtl/cache_line_array.sv | 63 ++++++
 rtl/cache_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory-request subsystem: word/line geometry,
// address field widths and the cache controller state encoding.
package mem_sys_pkg;

    localparam int ADDR_BITS      = 16;
    localparam int WORD_BITS      = 16;
    localparam int LINE_WORDS     = 4;
    localparam int WORD_SEL_BITS  = 2;
    localparam int BYTE_SEL_BITS  = 1;
    localparam int OFFSET_BITS    = WORD_SEL_BITS + BYTE_SEL_BITS;
    localparam int DEF_INDEX_BITS = 4;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_WMEM,
        ST_DONE
    } state_t;

    // Whatever address bits are left above the index form the tag.
    function automatic int tag_bits(input int index_bits);
        return ADDR_BITS - OFFSET_BITS - index_bits;
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Bundles the processor request/response signals and the backing-memory
// handshake. The slave view is the cache controller; the master view is the
// environment that issues requests and plays the backing memory.
interface cache_ctrl_if;

    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic        createdump;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  Addr, DataIn, Rd, Wr, createdump, mem_rdata, mem_ack,
        output DataOut, Done, Stall, CacheHit, err,
               mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output Addr, DataIn, Rd, Wr, createdump, mem_rdata, mem_ack,
        input  DataOut, Done, Stall, CacheHit, err,
               mem_addr, mem_rd, mem_wr, mem_wdata
    );

endinterface

// File: rtl/cache_line_array.sv
// Line storage for the direct-mapped cache: one valid bit, one tag and four
// data words per line. Only the valid bits are reset; tag and data contents
// are meaningless until the line is marked valid.
module cache_line_array
    import mem_sys_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = tag_bits(DEF_INDEX_BITS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INDEX_BITS-1:0]         rd_index,
    output logic                          rd_valid,
    output logic [TAG_BITS-1:0]           rd_tag,
    output word_t [LINE_WORDS-1:0]        rd_line,
    input  logic                          wr_en,
    input  logic [INDEX_BITS-1:0]         wr_index,
    input  logic [WORD_SEL_BITS-1:0]      wr_word,
    input  word_t                         wr_data,
    input  logic                          set_en,
    input  logic [INDEX_BITS-1:0]         set_index,
    input  logic [TAG_BITS-1:0]           set_tag
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]        valid_q;
    logic [LINES-1:0]        valid_d;
    logic [TAG_BITS-1:0]     tag_mem  [LINES];
    word_t [LINE_WORDS-1:0]  data_mem [LINES];

    // A line becomes valid only once its fill has fully completed.
    always_comb begin
        valid_d = valid_q;
        if (set_en) begin
            valid_d[set_index] = 1'b1;
        end
    end

    // Valid bits clear asynchronously so a reset mid-fill leaves no half line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage are plain memories with no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index][wr_word] <= wr_data;
        end
        if (set_en) begin
            tag_mem[set_index] <= set_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller. Hits are answered from the
// line array, read misses fill a whole line from backing memory, and every
// write goes to backing memory (updating the line only when it already hits).
module cache_ctrl
    import mem_sys_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.slave  bus
);

    localparam int TAG_BITS = tag_bits(INDEX_BITS);

    state_t                   state_q, state_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    word_t                    wdata_q, wdata_d;
    logic                     wr_op_q, wr_op_d;
    logic                     hit_q, hit_d;
    logic [WORD_SEL_BITS-1:0] cnt_q, cnt_d;
    logic                     done_q, done_d;
    word_t                    dout_q, dout_d;
    logic                     chit_q, chit_d;
    logic                     err_q, err_d;
    logic                     stall_q, stall_d;

    logic [WORD_SEL_BITS-1:0] req_word;
    logic [INDEX_BITS-1:0]    req_index;
    logic [TAG_BITS-1:0]      req_tag;

    logic                     line_valid;
    logic [TAG_BITS-1:0]      line_tag;
    word_t [LINE_WORDS-1:0]   line_data;
    logic                     lookup_hit;

    logic                     arr_wr_en;
    logic [WORD_SEL_BITS-1:0] arr_wr_word;
    word_t                    arr_wr_data;
    logic                     arr_set_en;

    logic [ADDR_BITS-1:0]     mem_addr_c;
    logic                     mem_rd_c;
    logic                     mem_wr_c;
    word_t                    mem_wdata_c;

    logic                     unused_createdump;

    assign req_word   = addr_q[OFFSET_BITS-1:BYTE_SEL_BITS];
    assign req_index  = addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign req_tag    = addr_q[ADDR_BITS-1:OFFSET_BITS+INDEX_BITS];
    assign lookup_hit = line_valid && (line_tag == req_tag);

    cache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (req_index),
        .rd_valid   (line_valid),
        .rd_tag     (line_tag),
        .rd_line    (line_data),
        .wr_en      (arr_wr_en),
        .wr_index   (req_index),
        .wr_word    (arr_wr_word),
        .wr_data    (arr_wr_data),
        .set_en     (arr_set_en),
        .set_index  (req_index),
        .set_tag    (req_tag)
    );

    // Next-state, request latching, line updates and memory handshake.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_op_d     = wr_op_q;
        hit_d       = hit_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        dout_d      = '0;
        chit_d      = 1'b0;
        err_d       = 1'b0;
        stall_d     = 1'b0;
        arr_wr_en   = 1'b0;
        arr_wr_word = '0;
        arr_wr_data = '0;
        arr_set_en  = 1'b0;
        mem_addr_c  = '0;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_wdata_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.Rd || bus.Wr) begin
                    addr_d  = bus.Addr;
                    wdata_d = bus.DataIn;
                    wr_op_d = bus.Wr;
                    if ((bus.Rd && bus.Wr) || bus.Addr[0]) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOOKUP;
                        stall_d = 1'b1;
                    end
                end
            end

            ST_LOOKUP: begin
                hit_d = lookup_hit;
                if (!wr_op_q) begin
                    if (lookup_hit) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        chit_d  = 1'b1;
                        dout_d  = line_data[req_word];
                    end else begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                        stall_d = 1'b1;
                    end
                end else begin
                    state_d = ST_WMEM;
                    stall_d = 1'b1;
                    if (lookup_hit) begin
                        arr_wr_en   = 1'b1;
                        arr_wr_word = req_word;
                        arr_wr_data = wdata_q;
                    end
                end
            end

            ST_FILL: begin
                mem_rd_c   = 1'b1;
                mem_addr_c = {req_tag, req_index, cnt_q, 1'b0};
                stall_d    = 1'b1;
                if (bus.mem_ack) begin
                    arr_wr_en   = 1'b1;
                    arr_wr_word = cnt_q;
                    arr_wr_data = bus.mem_rdata;
                    cnt_d       = cnt_q + 2'd1;
                    if (cnt_q == WORD_SEL_BITS'(LINE_WORDS - 1)) begin
                        arr_set_en = 1'b1;
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        stall_d    = 1'b0;
                        dout_d     = (req_word == cnt_q) ? bus.mem_rdata
                                                         : line_data[req_word];
                    end
                end
            end

            ST_WMEM: begin
                mem_wr_c    = 1'b1;
                mem_addr_c  = addr_q;
                mem_wdata_c = wdata_q;
                stall_d     = 1'b1;
                if (bus.mem_ack) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    chit_d  = hit_q;
                    stall_d = 1'b0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_op_q <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            chit_q  <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_op_q <= wr_op_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            chit_q  <= chit_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign bus.Done      = done_q;
    assign bus.DataOut   = dout_q;
    assign bus.CacheHit  = chit_q;
    assign bus.err       = err_q;
    assign bus.Stall     = stall_q;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_rd    = mem_rd_c;
    assign bus.mem_wr    = mem_wr_c;
    assign bus.mem_wdata = mem_wdata_c;

    assign unused_createdump = bus.createdump;

endmodule
